// File: rtl/atpg_pkg.sv
// Shared constants and types for the ATPG dictionary-coded stream path.
// Holds the pattern/code widths, the escape code and the packer state enum.
package atpg_pkg;

  localparam int unsigned PAT_W     = 9;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned RAW_SYM_W = CODE_W + PAT_W;
  localparam int unsigned SYM_LEN_W = 4;

  localparam logic [CODE_W-1:0] ESC_CODE = 4'hF;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

endpackage

// File: rtl/packer_symbol_fmt.sv
// Symbol formatter: turns a dictionary code (plus raw pattern on a miss)
// into a left-aligned variable-length symbol.
// Ports:
//   in_code    dictionary code, ESC_CODE means miss
//   in_pattern raw ATPG pattern, only used on a miss
//   sym_bits   symbol, left-aligned; unused low bits are zero
//   sym_len    number of valid bits in sym_bits (4 or 13)
module packer_symbol_fmt
  import atpg_pkg::*;
(
  input  logic [CODE_W-1:0]    in_code,
  input  logic [PAT_W-1:0]     in_pattern,
  output logic [RAW_SYM_W-1:0] sym_bits,
  output logic [SYM_LEN_W-1:0] sym_len
);

  // Hit: code only. Miss: escape followed by the raw pattern.
  always_comb begin
    sym_bits = {in_code, {PAT_W{1'b0}}};
    sym_len  = SYM_LEN_W'(CODE_W);
    if (in_code == ESC_CODE) begin
      sym_bits = {ESC_CODE, in_pattern};
      sym_len  = SYM_LEN_W'(RAW_SYM_W);
    end
  end

endmodule

// File: rtl/atpg_stream_packer.sv
// Packs hit codes and escaped raw patterns MSB-first into OUT_W-bit words
// on a valid/ready stream for the tester-side decompressor.
// Optional feature: define PACKER_STATS_EN to add saturating hit/miss
// counters (hit_count, miss_count).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     symbol input handshake
//   in_pattern, in_code   raw pattern and dictionary code (ESC_CODE = miss)
//   flush_req             one-cycle request to drain and pad the accumulator
//   flush_done            one-cycle pulse when a flush completes
//   out_valid/out_ready   word output handshake
//   out_data              packed word, first stream bit at MSB
//   out_last              final word of a flush
//   hit_count/miss_count  accepted hits/misses (PACKER_STATS_EN only)
module atpg_stream_packer
  import atpg_pkg::*;
#(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PAT_W-1:0]  in_pattern,
  input  logic [CODE_W-1:0] in_code,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
`ifdef PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  localparam int unsigned ACC_W  = OUT_W + RAW_SYM_W;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  if (OUT_W < 4 || OUT_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("atpg_stream_packer: OUT_W must be 4..32 and CNT_W >= 1");
  end

  pack_state_e          state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 flush_done_q, flush_done_d;

  logic [RAW_SYM_W-1:0] sym_bits;
  logic [SYM_LEN_W-1:0] sym_len;
  logic                 push, pop;
  logic [FILL_W-1:0]    pop_amt;
  logic [ACC_W-1:0]     acc_shift;
  logic [FILL_W-1:0]    fill_shift;

  packer_symbol_fmt u_fmt (
    .in_code    (in_code),
    .in_pattern (in_pattern),
    .sym_bits   (sym_bits),
    .sym_len    (sym_len)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Pop first, then append the new symbol right after the surviving bits.
  // in_ready guarantees fill_shift <= OUT_W on a push, so the symbol fits.
  always_comb begin
    pop_amt    = (fill_q < OUT_W_F) ? fill_q : OUT_W_F;
    acc_shift  = acc_q;
    fill_shift = fill_q;
    if (pop) begin
      acc_shift  = acc_q << OUT_W;
      fill_shift = fill_q - pop_amt;
    end
    acc_d  = acc_shift;
    fill_d = fill_shift;
    if (push) begin
      acc_d  = acc_shift | ({sym_bits, {OUT_W{1'b0}}} >> fill_shift);
      fill_d = fill_shift + FILL_W'(sym_len);
    end
  end

  // Next-state and next-output logic; outputs are registered from the
  // next-cycle view so they are pure flop outputs.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (fill_q == '0) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    in_ready_d  = (state_d == RUN) && (fill_d <= OUT_W_F);
    out_valid_d = (fill_d >= OUT_W_F) || ((state_d == FLUSH) && (fill_d != '0));
    out_last_d  = (state_d == FLUSH) && (fill_d != '0) && (fill_d <= OUT_W_F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign flush_done = flush_done_q;
  // Bits past fill are always zero, so the top slice is already padded.
  assign out_data   = acc_q[ACC_W-1 -: OUT_W];

`ifdef PACKER_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (push) begin
      if (in_code == ESC_CODE) begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end else begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_atpg_stream_packer.sv
// Directed self-checking bench for atpg_stream_packer with OUT_W=8.
module tb_atpg_stream_packer;

  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       in_pattern;
  logic [3:0]       in_code;
  logic             flush_req;
  logic             flush_done;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
`ifdef PACKER_STATS_EN
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
`endif

  int vectors;
  int miscompares;

  atpg_stream_packer #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .in_code    (in_code),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef PACKER_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a symbol until accepted, bounded by a cycle budget.
  task automatic push(input logic [3:0] code, input logic [8:0] pat);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_code    = code;
    in_pattern = pat;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_pattern  = '0;
    in_code     = '0;
    flush_req   = 1'b0;
    out_ready   = 1'b1;

    // Reset state
    tick();
    chk("rst_out_valid",  32'(out_valid),  32'(0));
    chk("rst_out_data",   32'(out_data),   32'(0));
    chk("rst_out_last",   32'(out_last),   32'(0));
    chk("rst_in_ready",   32'(in_ready),   32'(1));
    chk("rst_flush_done", 32'(flush_done), 32'(0));
    rst_n = 1'b1;
    tick();

    // Two hits fill exactly one word: 1,2 -> 8'h12
    in_valid = 1'b1; in_code = 4'h1;
    tick();
    chk("t1_valid_after_1", 32'(out_valid), 32'(0));
    in_code = 4'h2;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'(1));
    chk("t1_data",  32'(out_data),  32'h12);
    chk("t1_last",  32'(out_last),  32'(0));
    tick();
    chk("t1_drained", 32'(out_valid), 32'(0));

    // Miss + flush: FA then A8 (last)
    in_valid = 1'b1; in_code = 4'hF; in_pattern = 9'b101010101;
    tick();
    in_valid = 1'b0;
    chk("t2_valid0", 32'(out_valid), 32'(1));
    chk("t2_data0",  32'(out_data),  32'hFA);
    chk("t2_last0",  32'(out_last),  32'(0));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t2_in_ready_flush", 32'(in_ready),   32'(0));
    chk("t2_valid1",         32'(out_valid),  32'(1));
    chk("t2_data1",          32'(out_data),   32'hA8);
    chk("t2_last1",          32'(out_last),   32'(1));
    chk("t2_done_early",     32'(flush_done), 32'(0));
    tick();
    chk("t2_empty",      32'(out_valid),  32'(0));
    chk("t2_done_early2", 32'(flush_done), 32'(0));
    tick();
    chk("t2_done",       32'(flush_done), 32'(1));
    chk("t2_in_ready",   32'(in_ready),   32'(1));
    tick();
    chk("t2_done_pulse", 32'(flush_done), 32'(0));

    // Backpressure: hits 1,2,3 with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 4'h1;
    tick();
    in_code = 4'h2;
    tick();
    chk("t3_ready_fill8", 32'(in_ready), 32'(1));
    in_code = 4'h3;
    tick();
    in_valid = 1'b0;
    chk("t3_ready_fill12", 32'(in_ready),  32'(0));
    chk("t3_valid",        32'(out_valid), 32'(1));
    chk("t3_data",         32'(out_data),  32'h12);
    tick();
    chk("t3_data_held",    32'(out_data),  32'h12);
    chk("t3_valid_held",   32'(out_valid), 32'(1));
    out_ready = 1'b1;
    tick();
    chk("t3_popped",     32'(out_valid), 32'(0));
    chk("t3_ready_back", 32'(in_ready),  32'(1));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t3_pad_data", 32'(out_data), 32'h30);
    chk("t3_pad_last", 32'(out_last), 32'(1));
    tick();
    tick();
    chk("t3_done", 32'(flush_done), 32'(1));
    tick();

    // Empty flush: no word, done two cycles after request
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t4_valid",    32'(out_valid),  32'(0));
    chk("t4_in_ready", 32'(in_ready),   32'(0));
    chk("t4_done0",    32'(flush_done), 32'(0));
    tick();
    chk("t4_done",     32'(flush_done), 32'(1));
    chk("t4_valid2",   32'(out_valid),  32'(0));
    tick();

    // Reset mid-flush with a partial word pending
    in_valid = 1'b1; in_code = 4'hF; in_pattern = 9'b101010101;
    tick();
    in_valid  = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    out_ready = 1'b0;
    chk("t5_pre_valid", 32'(out_valid), 32'(1));
    chk("t5_pre_last",  32'(out_last),  32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid",    32'(out_valid), 32'(0));
    chk("t5_data",     32'(out_data),  32'(0));
    chk("t5_in_ready", 32'(in_ready),  32'(1));
    chk("t5_last",     32'(out_last),  32'(0));
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t5_post_valid", 32'(out_valid),  32'(0));
    chk("t5_post_last",  32'(out_last),   32'(0));
    tick();
    chk("t5_no_done",    32'(flush_done), 32'(0));

`ifdef PACKER_STATS_EN
    chk("st_hit_rst",  32'(hit_count),  32'(0));
    chk("st_miss_rst", 32'(miss_count), 32'(0));
    push(4'h0, 9'h000);
    push(4'hE, 9'h000);
    push(4'hF, 9'h1FF);
    push(4'hF, 9'h055);
    push(4'h7, 9'h000);
    chk("st_hit3",  32'(hit_count),  32'(3));
    chk("st_miss2", 32'(miss_count), 32'(2));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("st_hit_keep",  32'(hit_count),  32'(3));
    chk("st_miss_keep", 32'(miss_count), 32'(2));
    in_valid = 1'b1; in_code = 4'h5;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("st_hit_sat",  32'(hit_count),  32'hFFFF);
    chk("st_miss_sat", 32'(miss_count), 32'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
